// File: rtl/thunderbird_light_controller.sv
// Thunderbird tail-light sequencer: prescaled step strobe, turn/hazard FSM and brake overlay.
// Optional turn auto-cancel after MAX_CYCLES full sequences is built when TB_AUTOCANCEL_EN is defined.
module thunderbird_light_controller #(
  parameter int unsigned TICK_DIV   = 4,
  parameter int unsigned CNT_W      = 24,
  parameter int unsigned MAX_CYCLES = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic B,
  input  logic L,
  input  logic R,
  input  logic H,
  output logic LA,
  output logic LB,
  output logic LC,
  output logic RA,
  output logic RB,
  output logic RC,
  output logic tick
);

  if (TICK_DIV < 2 || TICK_DIV > (1 << 24) || $clog2(TICK_DIV) > CNT_W ||
      MAX_CYCLES < 1 || MAX_CYCLES > 15) begin : g_bad_cfg
    $error("thunderbird_light_controller: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_L1   = 3'd1,
    S_L2   = 3'd2,
    S_L3   = 3'd3,
    S_R1   = 3'd4,
    S_R2   = 3'd5,
    S_R3   = 3'd6,
    S_HAZ  = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_s;
  state_t           state_q, state_d;
  logic [2:0]       left_q, left_d;    // {LC, LB, LA}
  logic [2:0]       right_q, right_d;  // {RC, RB, RA}
  logic             haz_s, left_s, right_s;
  logic             cancel_l_s, cancel_r_s;
  logic             left_seq_s, right_seq_s, brake_en_s;

  assign tick_s  = (cnt_q == CNT_LAST);
  assign haz_s   = H | (L & R);
  assign left_s  = L & ~R & ~H;
  assign right_s = R & ~L & ~H;

  // Step prescaler: counts 0..TICK_DIV-1 and wraps on the strobe cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (tick_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

`ifdef TB_AUTOCANCEL_EN
  localparam logic [3:0] WRAP_MAX = 4'(MAX_CYCLES);

  logic [3:0] wraps_q, wraps_d;
  logic       side_q, side_d;  // side of the last turn request, 1 = right

  // Count completed sequences per side; any gap or direction change restarts the count.
  always_comb begin
    wraps_d = wraps_q;
    side_d  = side_q;
    if (tick_s) begin
      if (!left_s && !right_s) begin
        wraps_d = 4'd0;
      end else begin
        if (right_s != side_q) begin
          side_d  = right_s;
          wraps_d = 4'd0;
        end else begin
          wraps_d = wraps_q;
        end
        if (((state_q == S_L3) && left_s) || ((state_q == S_R3) && right_s)) begin
          if (wraps_d != 4'hF) begin
            wraps_d = wraps_d + 4'd1;
          end else begin
            wraps_d = wraps_d;
          end
        end else begin
          wraps_d = wraps_d;
        end
      end
    end else begin
      wraps_d = wraps_q;
    end
  end

  assign cancel_l_s = left_s  && !side_q && (wraps_q >= WRAP_MAX);
  assign cancel_r_s = right_s &&  side_q && (wraps_q >= WRAP_MAX);

  // Auto-cancel bookkeeping registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wraps_q <= 4'd0;
      side_q  <= 1'b0;
    end else begin
      wraps_q <= wraps_d;
      side_q  <= side_d;
    end
  end
`else
  assign cancel_l_s = 1'b0;
  assign cancel_r_s = 1'b0;
`endif

  // Next-state logic; the state only advances on the step strobe.
  always_comb begin
    state_d = state_q;
    if (tick_s) begin
      if (haz_s) begin
        state_d = (state_q == S_IDLE) ? S_HAZ : S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (left_s && !cancel_l_s) begin
              state_d = S_L1;
            end else if (right_s && !cancel_r_s) begin
              state_d = S_R1;
            end else begin
              state_d = S_IDLE;
            end
          end
          S_L1:    state_d = left_s  ? S_L2 : S_IDLE;
          S_L2:    state_d = left_s  ? S_L3 : S_IDLE;
          S_R1:    state_d = right_s ? S_R2 : S_IDLE;
          S_R2:    state_d = right_s ? S_R3 : S_IDLE;
          S_L3:    state_d = S_IDLE;
          S_R3:    state_d = S_IDLE;
          S_HAZ:   state_d = S_IDLE;
          default: state_d = S_IDLE;
        endcase
      end
    end else begin
      state_d = state_q;
    end
  end

  assign left_seq_s  = (state_d == S_L1) || (state_d == S_L2) || (state_d == S_L3);
  assign right_seq_s = (state_d == S_R1) || (state_d == S_R2) || (state_d == S_R3);
  // Brake is ignored in hazard and in the all-off steps between hazard phases.
  assign brake_en_s  = B && (state_d != S_HAZ) && !((state_d == S_IDLE) && haz_s);

  // Lamp decode of the upcoming state with brake overlay on the non-sequencing side(s).
  always_comb begin
    left_d  = 3'b000;
    right_d = 3'b000;
    case (state_d)
      S_L1:    left_d  = 3'b001;
      S_L2:    left_d  = 3'b011;
      S_L3:    left_d  = 3'b111;
      S_R1:    right_d = 3'b001;
      S_R2:    right_d = 3'b011;
      S_R3:    right_d = 3'b111;
      S_HAZ: begin
        left_d  = 3'b111;
        right_d = 3'b111;
      end
      default: begin
        left_d  = 3'b000;
        right_d = 3'b000;
      end
    endcase
    if (brake_en_s) begin
      if (!left_seq_s) begin
        left_d = 3'b111;
      end else begin
        left_d = left_d;
      end
      if (!right_seq_s) begin
        right_d = 3'b111;
      end else begin
        right_d = right_d;
      end
    end else begin
      left_d  = left_d;
      right_d = right_d;
    end
  end

  // State, prescaler, strobe and lamp registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      state_q <= S_IDLE;
      left_q  <= 3'b000;
      right_q <= 3'b000;
    end else begin
      cnt_q   <= cnt_d;
      tick_q  <= (cnt_d == CNT_LAST);
      state_q <= state_d;
      left_q  <= left_d;
      right_q <= right_d;
    end
  end

  assign tick = tick_q;
  assign LA   = left_q[0];
  assign LB   = left_q[1];
  assign LC   = left_q[2];
  assign RA   = right_q[0];
  assign RB   = right_q[1];
  assign RC   = right_q[2];

endmodule

// File: tb/tb_thunderbird_light_controller.sv
// Self-checking bench for thunderbird_light_controller: vector table, hand sequences and
// randomized inputs against a lamp-count reference model. Honours TB_AUTOCANCEL_EN.
module tb_thunderbird_light_controller;

  localparam int TICK_DIV = 4;
  localparam int MAX_CYC  = 2;

  logic clock = 1'b0;
  logic reset, B, L, R, H;
  logic LA, LB, LC, RA, RB, RC, tick;

  int checks = 0;
  int errors = 0;

  thunderbird_light_controller #(
    .TICK_DIV  (TICK_DIV),
    .CNT_W     (24),
    .MAX_CYCLES(MAX_CYC)
  ) u_dut (
    .clock(clock), .reset(reset),
    .B(B), .L(L), .R(R), .H(H),
    .LA(LA), .LB(LB), .LC(LC),
    .RA(RA), .RB(RB), .RC(RC),
    .tick(tick)
  );

  always #5 clock = ~clock;

  // Lamps as {LC,LB,LA,RA,RB,RC}: outermost left to outermost right.
  function automatic logic [5:0] lamps();
    return {LC, LB, LA, RA, RB, RC};
  endfunction

  // Reference model: which side is running, how many of its lamps are lit, hazard phase.
  int         cyc;
  int         m_side;   // 0 none, 1 left, 2 right
  int         m_lit;    // lamps lit on the running side, 0..3
  bit         m_haz;
  int         m_last;   // side of the last turn request, 0 none
  int         m_wraps;
  logic [5:0] exp_lamps;

  function automatic logic [2:0] lbar(input int n);   // {LC,LB,LA}
    return (n <= 0) ? 3'b000 : (n == 1) ? 3'b001 : (n == 2) ? 3'b011 : 3'b111;
  endfunction

  function automatic logic [2:0] rbar(input int n);   // {RA,RB,RC}
    return (n <= 0) ? 3'b000 : (n == 1) ? 3'b100 : (n == 2) ? 3'b110 : 3'b111;
  endfunction

  task automatic model_step();
    bit hz, lq, rq, idle, blocked;
    hz = H | (L & R);
    lq = L & !R & !H;
    rq = R & !L & !H;
    blocked = 1'b0;
`ifdef TB_AUTOCANCEL_EN
    blocked = ((lq && m_last == 1) || (rq && m_last == 2)) && (m_wraps >= MAX_CYC);
    if (!lq && !rq) m_wraps = 0;
    else if ((lq ? 1 : 2) != m_last) begin
      m_last  = lq ? 1 : 2;
      m_wraps = 0;
    end
`endif
    idle = (m_lit == 0) && !m_haz;
    if (hz) begin
      if (idle) m_haz = 1'b1;
      else begin
        m_haz = 1'b0; m_lit = 0; m_side = 0;
      end
    end else if (m_haz) begin
      m_haz = 1'b0;
    end else if (idle) begin
      if (lq && !blocked) begin m_side = 1; m_lit = 1; end
      else if (rq && !blocked) begin m_side = 2; m_lit = 1; end
    end else if ((m_side == 1) ? lq : rq) begin
      m_lit = (m_lit + 1) % 4;
      if (m_lit == 0) begin
        m_side = 0;
        if (m_wraps < 15) m_wraps++;
      end
    end else begin
      m_lit = 0; m_side = 0;
    end
  endtask

  function automatic logic [5:0] model_lamps();
    logic [2:0] l3, r3;
    bit hz;
    hz = H | (L & R);
    l3 = m_haz ? 3'b111 : (m_side == 1) ? lbar(m_lit) : 3'b000;
    r3 = m_haz ? 3'b111 : (m_side == 2) ? rbar(m_lit) : 3'b000;
    if (B && !m_haz && !(hz && m_lit == 0)) begin
      if (m_side != 1) l3 = 3'b111;
      if (m_side != 2) r3 = 3'b111;
    end
    return {l3, r3};
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      cyc = 0; m_side = 0; m_lit = 0; m_haz = 1'b0;
      m_last = 0; m_wraps = 0; exp_lamps = 6'b000000;
    end else begin
      if (cyc % TICK_DIV == TICK_DIV - 1) model_step();
      cyc++;
      exp_lamps = model_lamps();
    end
  end

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // One clock: drive inputs, let the edge pass, compare against the model.
  task automatic cycle(input logic b, input logic l, input logic r, input logic h);
    B = b; L = l; R = r; H = h;
    @(posedge clock);
    @(negedge clock);
    chk("model_lamps", lamps(), exp_lamps);
    chk("model_tick", {5'b00000, tick},
        {5'b00000, (!reset && (cyc % TICK_DIV == TICK_DIV - 1))});
  endtask

  task automatic step(input logic b, input logic l, input logic r, input logic h);
    for (int i = 0; i < TICK_DIV; i++) cycle(b, l, r, h);
  endtask

  typedef struct {
    logic       b, l, r, h;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[21];

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b000_000};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 6'b001_000};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 6'b011_000};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 6'b111_000};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 6'b000_000};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 6'b001_000};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 6'b011_000};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b000_000};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 6'b111_100};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 6'b111_110};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 6'b111_111};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 6'b111_111};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'b111_111};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 6'b000_100};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 6'b000_110};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 6'b000_000};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b1, 6'b111_111};
    tbl[17] = '{1'b1, 1'b0, 1'b0, 1'b1, 6'b000_000};
    tbl[18] = '{1'b1, 1'b1, 1'b1, 1'b0, 6'b111_111};
    tbl[19] = '{1'b0, 1'b1, 1'b1, 1'b0, 6'b000_000};
    tbl[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b000_000};

    reset = 1'b1; B = 1'b0; L = 1'b0; R = 1'b0; H = 1'b0;
    repeat (2) @(negedge clock);
    chk("reset_lamps", lamps(), 6'b000000);
    chk("reset_tick", {5'b00000, tick}, 6'b000000);
    reset = 1'b0;

    // Idle: strobe exactly in cycles 3, 7, 11 after reset release.
    for (int k = 1; k <= 12; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("tick_cycle_%0d", k), {5'b00000, tick},
          {5'b00000, (k == 3 || k == 7 || k == 11)});
    end

    foreach (tbl[i]) begin
      step(tbl[i].b, tbl[i].l, tbl[i].r, tbl[i].h);
      chk($sformatf("vec_%0d", i), lamps(), tbl[i].exp);
    end

    // Reset for one cycle while in L3 with brake applied.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("pre_reset_L3", lamps(), 6'b111_000);
    reset = 1'b1;
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    chk("midseq_reset_lamps", lamps(), 6'b000000);
    chk("midseq_reset_tick", {5'b00000, tick}, 6'b000000);
    reset = 1'b0;
    for (int k = 1; k <= 3; k++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("post_reset_first_tick", {5'b00000, tick}, 6'b000001);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("post_reset_restart_L1", lamps(), 6'b001_000);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_reset_idle", lamps(), 6'b000000);

`ifdef TB_AUTOCANCEL_EN
    // Two full left sequences, then the turn is cancelled until L drops for a tick.
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("autocancel_off_1", lamps(), 6'b000000);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("autocancel_off_2", lamps(), 6'b000000);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("autocancel_brake_only", lamps(), 6'b111_111);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("autocancel_restart", lamps(), 6'b001_000);
    step(1'b0, 1'b0, 1'b0, 1'b0);
`endif

    // Randomized inputs with occasional resets, compared every cycle with the model.
    for (int k = 0; k < 3000; k++) begin
      logic [3:0] in_v;
      in_v = {B, L, R, H};
      if ($urandom_range(0, 5) == 0) in_v[$urandom_range(0, 3)] ^= 1'b1;
      reset = ($urandom_range(0, 399) == 0);
      cycle(in_v[3], in_v[2], in_v[1], in_v[0]);
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
